post_output_transposer: RTL and testbench
=========================================

POST_OUTPUT_TRANSPOSER -- requirements
Module: post_output_transposer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 39, meaning bits per coefficient.
REQ-002 SHALL have clk  input  1  clock; all logic on rising edge.
REQ-003 SHALL have rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have i_obuf_reset  input  1  synchronous clear of all counters, flags and outputs.
REQ-005 SHALL have i_obuf_start  input  1  single-cycle pulse starting a 6-polynomial readout.
REQ-006 SHALL have o_obuf_busy  output  1  high from the cycle after an accepted start until done.
REQ-007 SHALL have o_obuf_done  output  1  single-cycle pulse when the last beat is accepted.
REQ-008 SHALL have o_obuf_rden  output  48  bank read enables, p5b7..p0b7..p0b0, bit index = p*8+b.
REQ-009 SHALL have o_obuf_addr  output  72  9-bit bank read address per bank group b, at bits b*9 +: 9.
REQ-010 SHALL have i_obuf_data  input  8*DATA_WIDTH  group-b read data at b*DATA_WIDTH, valid 1 cycle after rden.
REQ-011 SHALL have o_beat_valid  output  1, i_beat_ready  input  1  beat handshake.
REQ-012 SHALL have o_beat_addr  output  12  beat index 0..3071; o_beat_data  output  8*DATA_WIDTH  8 coefficients.

Function
REQ-013 SHALL map beat A as polyn A[11:9], group A[8:6], word A[5:0]; lane j of the beat = coefficient A[5:0]*8+j of bank (polyn, group).
REQ-014 SHALL contain a fill engine reading all 8 groups in lockstep: counters fill_p (0..5), fill_k (0..511); per issue cycle, rden bits p=fill_p of every group high, every group addr = fill_k.
REQ-015 SHALL pack returned data per group into lane fill_k[2:0] (one-cycle delayed copy of k), writing the packed word to staging address k[8:3] of half fill_p[0] when delayed k[2:0]==7.
REQ-016 SHALL provide per group a 2-half x 64-word x 8*DATA_WIDTH staging buffer (ping-pong), combinational read.
REQ-017 SHALL set full[h] on the cycle the word for delayed k=511 is written; fill_p then increments, fill_k wraps to 0.
REQ-018 SHALL issue no read while full[fill_p[0]] is set (stall); rden all zero during stall, IDLE and after fill_p=5 completes.
REQ-019 Fill FSM states SHALL be IDLE -> FILL (on start) -> FDONE (after polyn 5 issued); FDONE -> IDLE on done.
REQ-020 SHALL contain a drain counter d (0..3071); half = d[9]; next beat loadable when full[d[9]] and (!o_beat_valid or i_beat_ready).
REQ-021 SHALL register o_beat_data/o_beat_addr on load; o_beat_valid stays high and data stable until accepted.
REQ-022 SHALL clear full[d[9]] on loading d[8:0]==511, same cycle fill may reuse the half on the next cycle.
REQ-023 Simultaneous set (fill) and clear (drain) of the same full bit SHALL not occur by construction; set SHALL win if it does.
REQ-024 SHALL pulse o_obuf_done on acceptance of beat 3071, clear busy same cycle, return to IDLE.
REQ-025 SHALL ignore i_obuf_start while busy.
REQ-026 Minimum latency start -> first o_beat_valid SHALL be 514 cycles; sustained throughput 1 beat/cycle with ready high.

Reset
REQ-027 On rst_n low all outputs SHALL be 0, FSM IDLE, counters 0, full[1:0]=0; buffer contents undefined.
REQ-028 i_obuf_reset SHALL have identical effect synchronously and SHALL override a same-cycle start; mid-operation it aborts with no done pulse.

Configuration
REQ-029 With macro POST_OUTPUT_TRANSPOSER_PERF_CNT_EN defined SHALL add output o_stall_cycles 16-bit, counting cycles with o_beat_valid & !i_beat_ready, saturating at 0xFFFF, cleared on start; undefined: port and counter absent.

Verification
REQ-030 Banks preloaded coeff = p*4096+b*512+k, start, ready=1 -> 3072 beats, addr 0..3071 in order, beat A lane j = (A>>9)*4096+((A>>6)&7)*512+(A&63)*8+j, done once.
REQ-031 Ready held low 2000 cycles after first valid -> beat 0 stable, fill stalls after 2 polyns, no rden high during stall, stream resumes intact.
REQ-032 Ready toggled 1-0 every cycle -> 6144 cycles of drain, all data correct, no duplicated/skipped addr.
REQ-033 i_obuf_reset asserted at beat 1000 -> valid/busy/rden 0 next cycle, no done; new start reproduces full sequence from addr 0.
REQ-034 Start pulse while busy at beat 500 -> ignored, sequence and single done unchanged.
REQ-035 With PERF_CNT_EN, 37 stalled valid cycles -> o_stall_cycles=37 after done.

Source files
------------

// File: rtl/post_output_transposer_if.sv
// Bundles the output-buffer read port, the start/busy/done control and the
// beat stream of post_output_transposer into one interface.
interface post_output_transposer_if #(
    parameter int DATA_WIDTH = 39
);
    logic                      i_obuf_reset;
    logic                      i_obuf_start;
    logic                      o_obuf_busy;
    logic                      o_obuf_done;
    logic [47:0]               o_obuf_rden;
    logic [71:0]               o_obuf_addr;
    logic [8*DATA_WIDTH-1:0]   i_obuf_data;
    logic                      o_beat_valid;
    logic                      i_beat_ready;
    logic [11:0]               o_beat_addr;
    logic [8*DATA_WIDTH-1:0]   o_beat_data;

    modport master (
        input  i_obuf_reset, i_obuf_start, i_obuf_data, i_beat_ready,
        output o_obuf_busy, o_obuf_done, o_obuf_rden, o_obuf_addr,
               o_beat_valid, o_beat_addr, o_beat_data
    );

    modport slave (
        output i_obuf_reset, i_obuf_start, i_obuf_data, i_beat_ready,
        input  o_obuf_busy, o_obuf_done, o_obuf_rden, o_obuf_addr,
               o_beat_valid, o_beat_addr, o_beat_data
    );
endinterface

// File: rtl/post_output_transposer.sv
// Reads 6 polynomials x 8 bank groups in lockstep, transposes through ping-pong staging
// buffers and streams 3072 beats of 8 coefficients. Optional: POST_OUTPUT_TRANSPOSER_PERF_CNT_EN.
module post_output_transposer #(
    parameter int DATA_WIDTH = 39
) (
    input  logic clk,
    input  logic rst_n,
    post_output_transposer_if.master bus
`ifdef POST_OUTPUT_TRANSPOSER_PERF_CNT_EN
    ,
    output logic [15:0] o_stall_cycles
`endif
);

    localparam int W = 8 * DATA_WIDTH;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        FDONE = 2'd2
    } fill_state_t;

    fill_state_t state_reg, state_next;

    logic [2:0]   fill_p_reg;
    logic [8:0]   fill_k_reg;
    logic         busy_reg;
    logic         done_reg;
    logic [1:0]   full_reg;

    // read-return pipeline: describes the data arriving on i_obuf_data this cycle
    logic         rd_vld_reg;
    logic [8:0]   rd_k_reg;
    logic         rd_half_reg;

    logic [11:0]  drain_reg;
    logic         beat_valid_reg;
    logic [11:0]  beat_addr_reg;
    logic [W-1:0] beat_data_reg;

    logic         start_ok;
    logic         issue;
    logic         accept;
    logic         last_accept;
    logic         load;
    logic         last_issue;
    logic [47:0]  rden;
    logic [W-1:0] grp_rd [8];
    logic [W-1:0] beat_next;

    assign start_ok    = bus.i_obuf_start && !busy_reg && !bus.i_obuf_reset;
    assign accept      = beat_valid_reg && bus.i_beat_ready;
    assign last_accept = accept && (beat_addr_reg == 12'd3071);
    assign load        = busy_reg && full_reg[drain_reg[9]] && (!beat_valid_reg || bus.i_beat_ready);
    assign last_issue  = issue && (fill_k_reg == 9'd511) && (fill_p_reg == 3'd5);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        issue      = 1'b0;
        case (state_reg)
            IDLE: begin
                if (start_ok) state_next = FILL;
            end
            FILL: begin
                // a half still owned by the drain side blocks the next polynomial
                issue = !full_reg[fill_p_reg[0]];
                if (last_issue) state_next = FDONE;
            end
            FDONE: begin
                if (last_accept) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
        if (bus.i_obuf_reset) state_next = IDLE;
    end

    generate
        for (genvar gi = 0; gi < 6; gi++) begin : g_rden
            assign rden[gi*8 +: 8] = {8{issue && (fill_p_reg == 3'(gi))}};
        end
    endgenerate

    assign bus.o_obuf_rden = rden;
    assign bus.o_obuf_addr = issue ? {8{fill_k_reg}} : 72'd0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fill_p_reg     <= 3'd0;
            fill_k_reg     <= 9'd0;
            busy_reg       <= 1'b0;
            done_reg       <= 1'b0;
            full_reg       <= 2'b00;
            rd_vld_reg     <= 1'b0;
            rd_k_reg       <= 9'd0;
            rd_half_reg    <= 1'b0;
            drain_reg      <= 12'd0;
            beat_valid_reg <= 1'b0;
            beat_addr_reg  <= 12'd0;
            beat_data_reg  <= '0;
        end else if (bus.i_obuf_reset) begin
            fill_p_reg     <= 3'd0;
            fill_k_reg     <= 9'd0;
            busy_reg       <= 1'b0;
            done_reg       <= 1'b0;
            full_reg       <= 2'b00;
            rd_vld_reg     <= 1'b0;
            rd_k_reg       <= 9'd0;
            rd_half_reg    <= 1'b0;
            drain_reg      <= 12'd0;
            beat_valid_reg <= 1'b0;
            beat_addr_reg  <= 12'd0;
            beat_data_reg  <= '0;
        end else begin
            done_reg    <= last_accept;
            rd_vld_reg  <= issue;
            rd_k_reg    <= fill_k_reg;
            rd_half_reg <= fill_p_reg[0];

            if (start_ok) begin
                fill_p_reg <= 3'd0;
                fill_k_reg <= 9'd0;
                full_reg   <= 2'b00;
                drain_reg  <= 12'd0;
                busy_reg   <= 1'b1;
            end

            if (issue) begin
                fill_k_reg <= fill_k_reg + 9'd1;
                if (fill_k_reg == 9'd511 && fill_p_reg != 3'd5) begin
                    fill_p_reg <= fill_p_reg + 3'd1;
                end
            end

            // clear first so that a same-cycle set on the same half takes priority
            if (load && drain_reg[8:0] == 9'd511) begin
                full_reg[drain_reg[9]] <= 1'b0;
            end
            if (rd_vld_reg && rd_k_reg == 9'd511) begin
                full_reg[rd_half_reg] <= 1'b1;
            end

            if (load) begin
                drain_reg      <= (drain_reg == 12'd3071) ? 12'd0 : drain_reg + 12'd1;
                beat_valid_reg <= 1'b1;
                beat_addr_reg  <= drain_reg;
                beat_data_reg  <= beat_next;
            end else if (accept) begin
                beat_valid_reg <= 1'b0;
            end

            if (last_accept) busy_reg <= 1'b0;
        end
    end

    // Per-group transpose: lanes 0..6 collect in a pack register, lane 7 completes the word.
    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_group
            logic [DATA_WIDTH-1:0]   grp_data;
            logic [7*DATA_WIDTH-1:0] pack_reg;
            logic [W-1:0]            stage_mem [128];

            assign grp_data = bus.i_obuf_data[gi*DATA_WIDTH +: DATA_WIDTH];

            always_ff @(posedge clk) begin
                if (rd_vld_reg) begin
                    if (rd_k_reg[2:0] == 3'd7) begin
                        stage_mem[{rd_half_reg, rd_k_reg[8:3]}] <= {grp_data, pack_reg};
                    end else begin
                        pack_reg[rd_k_reg[2:0]*DATA_WIDTH +: DATA_WIDTH] <= grp_data;
                    end
                end
            end

            assign grp_rd[gi] = stage_mem[{drain_reg[9], drain_reg[5:0]}];
        end
    endgenerate

    assign beat_next = grp_rd[drain_reg[8:6]];

    assign bus.o_obuf_busy  = busy_reg;
    assign bus.o_obuf_done  = done_reg;
    assign bus.o_beat_valid = beat_valid_reg;
    assign bus.o_beat_addr  = beat_addr_reg;
    assign bus.o_beat_data  = beat_data_reg;

`ifdef POST_OUTPUT_TRANSPOSER_PERF_CNT_EN
    logic [15:0] stall_cnt_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_reg <= 16'd0;
        end else if (bus.i_obuf_reset || start_ok) begin
            stall_cnt_reg <= 16'd0;
        end else if (beat_valid_reg && !bus.i_beat_ready && stall_cnt_reg != 16'hFFFF) begin
            stall_cnt_reg <= stall_cnt_reg + 16'd1;
        end
    end

    assign o_stall_cycles = stall_cnt_reg;
`endif

endmodule

// File: tb/tb_post_output_transposer.sv
// Directed bench for post_output_transposer: bank model, normal / backpressure /
// toggled-ready / abort / start-while-busy runs against a closed-form beat formula.
module tb_post_output_transposer;

    localparam int DW = 39;
    localparam int W  = 8 * DW;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    post_output_transposer_if #(.DATA_WIDTH(DW)) bus ();

`ifdef POST_OUTPUT_TRANSPOSER_PERF_CNT_EN
    logic [15:0] stall_cycles;
`endif

    post_output_transposer #(.DATA_WIDTH(DW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
`ifdef POST_OUTPUT_TRANSPOSER_PERF_CNT_EN
        ,
        .o_stall_cycles (stall_cycles)
`endif
    );

    // bank model: coefficient k of bank (p, b) holds p*4096 + b*512 + k
    always @(posedge clk) begin
        for (int b = 0; b < 8; b++) begin
            for (int p = 0; p < 6; p++) begin
                if (bus.o_obuf_rden[p*8+b]) begin
                    bus.i_obuf_data[b*DW +: DW] <= DW'(p*4096 + b*512 + int'(bus.o_obuf_addr[b*9 +: 9]));
                end
            end
        end
    end

    int checks = 0;
    int fails  = 0;

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [W-1:0] exp_beat(input int a);
        logic [W-1:0] v;
        v = '0;
        for (int j = 0; j < 8; j++) begin
            v[j*DW +: DW] = DW'((a >> 9) * 4096 + ((a >> 6) & 7) * 512 + (a & 63) * 8 + j);
        end
        return v;
    endfunction

    task automatic pulse_start();
        @(negedge clk);
        bus.i_obuf_start = 1'b1;
        @(negedge clk);
        bus.i_obuf_start = 1'b0;
    endtask

    // mode 0: ready high; 1: ready low 2000 cycles after first valid; 2: ready toggles
    task automatic run(input int mode, input int abort_at, input int start_at);
        int cyc = 1;
        int exp_a = 0;
        int issue_n = 0;
        int dones = 0;
        int extra = 0;
        int first_valid = -1;
        bit aborted = 1'b0;
        logic [47:0] er;
        while (dones == 0 && !aborted && cyc < 20000) begin
            bus.i_obuf_start = 1'b0;
            if (cyc == 1) chk("busy_after_start", W'(bus.o_obuf_busy), W'(1'b1));
            if (|bus.o_obuf_rden) begin
                er = 48'hFF << (8 * (issue_n / 512));
                chk("rden", W'(bus.o_obuf_rden), W'(er));
                chk("raddr", W'(bus.o_obuf_addr), W'({8{9'(issue_n % 512)}}));
                issue_n++;
            end
            if (bus.o_obuf_done) begin
                dones++;
                chk("busy_at_done", W'(bus.o_obuf_busy), W'(1'b0));
            end
            if (bus.o_beat_valid && first_valid < 0) first_valid = cyc;
            case (mode)
                1:       bus.i_beat_ready = (first_valid >= 0) && (cyc >= first_valid + 2000);
                2:       bus.i_beat_ready = cyc[0];
                default: bus.i_beat_ready = 1'b1;
            endcase
            if (mode == 1 && first_valid >= 0 && cyc == first_valid + 2000) begin
                chk("issues_during_stall", W'(issue_n), W'(1024));
            end
            if (bus.o_beat_valid) begin
                chk("beat_addr", W'(bus.o_beat_addr), W'(exp_a));
                chk("beat_data", bus.o_beat_data, exp_beat(exp_a));
                if (start_at >= 0 && exp_a == start_at && bus.i_beat_ready) bus.i_obuf_start = 1'b1;
                if (abort_at >= 0 && exp_a == abort_at) begin
                    bus.i_obuf_reset = 1'b1;
                    aborted = 1'b1;
                end else if (bus.i_beat_ready) begin
                    exp_a++;
                end
            end
            @(negedge clk);
            cyc++;
        end
        bus.i_obuf_start = 1'b0;
        if (aborted) begin
            bus.i_obuf_reset = 1'b0;
            chk("abort_valid", W'(bus.o_beat_valid), W'(1'b0));
            chk("abort_busy", W'(bus.o_obuf_busy), W'(1'b0));
            chk("abort_rden", W'(bus.o_obuf_rden), W'(48'd0));
            for (int i = 0; i < 40; i++) begin
                if (bus.o_obuf_done || bus.o_beat_valid || (|bus.o_obuf_rden)) extra++;
                @(negedge clk);
            end
            chk("abort_quiet", W'(extra), W'(0));
        end else begin
            chk("done_count", W'(dones), W'(1));
            chk("beats_total", W'(exp_a), W'(3072));
            chk("issues_total", W'(issue_n), W'(3072));
            chk("busy_end", W'(bus.o_obuf_busy), W'(1'b0));
            if (mode == 0) chk("latency", W'(first_valid), W'(515));
            for (int i = 0; i < 20; i++) begin
                if (bus.o_obuf_done || bus.o_beat_valid) extra++;
                @(negedge clk);
            end
            chk("post_done_quiet", W'(extra), W'(0));
`ifdef POST_OUTPUT_TRANSPOSER_PERF_CNT_EN
            if (mode == 1) chk("stall_cycles", W'(stall_cycles), W'(16'd2000));
`endif
        end
    endtask

    initial begin
        bus.i_obuf_reset = 1'b0;
        bus.i_obuf_start = 1'b0;
        bus.i_beat_ready = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_valid", W'(bus.o_beat_valid), W'(1'b0));
        chk("rst_busy", W'(bus.o_obuf_busy), W'(1'b0));
        chk("rst_done", W'(bus.o_obuf_done), W'(1'b0));
        chk("rst_rden", W'(bus.o_obuf_rden), W'(48'd0));
        chk("rst_addr", W'(bus.o_obuf_addr), W'(72'd0));
        chk("rst_beat_addr", W'(bus.o_beat_addr), W'(12'd0));
        chk("rst_beat_data", bus.o_beat_data, '0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("idle_busy", W'(bus.o_obuf_busy), W'(1'b0));
        $display("step: normal run, ready high");
        pulse_start();
        run(0, -1, -1);
        $display("step: ready held low 2000 cycles");
        pulse_start();
        run(1, -1, -1);
        $display("step: ready toggling");
        pulse_start();
        run(2, -1, -1);
        $display("step: abort at beat 1000 then restart");
        pulse_start();
        run(0, 1000, -1);
        pulse_start();
        run(0, -1, -1);
        $display("step: start pulse while busy at beat 500");
        pulse_start();
        run(0, -1, 500);
        $display("step: start with same-cycle obuf reset");
        @(negedge clk);
        bus.i_obuf_start = 1'b1;
        bus.i_obuf_reset = 1'b1;
        @(negedge clk);
        bus.i_obuf_start = 1'b0;
        bus.i_obuf_reset = 1'b0;
        chk("start_reset_busy", W'(bus.o_obuf_busy), W'(1'b0));
        chk("start_reset_rden", W'(bus.o_obuf_rden), W'(48'd0));
        repeat (5) @(negedge clk);
        chk("start_reset_rden_later", W'(bus.o_obuf_rden), W'(48'd0));
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
